// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;

  // One fetched word together with the byte address it came from.
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus: imem address/data, redirect request and decode handshake.
interface ifetch_unit_if;

  logic [mips_pkg::WORD_W-1:0] adr;
  logic [mips_pkg::WORD_W-1:0] memdata;
  logic                        redirect;
  logic [mips_pkg::WORD_W-1:0] redirect_pc;
  logic                        instr_ready;
  logic                        instr_valid;
  logic [mips_pkg::WORD_W-1:0] instr;
  logic [mips_pkg::WORD_W-1:0] instr_pc;
  logic                        align_err;
  logic [mips_pkg::WORD_W-1:0] fetch_count;

  modport master (
    output adr, instr_valid, instr, instr_pc, align_err, fetch_count,
    input  memdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  adr, instr_valid, instr, instr_pc, align_err, fetch_count,
    output memdata, redirect, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched words; entry 0 is always the head. Flush beats push/pop.
module fetch_buf
  import mips_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   occ_o
);

  fetch_entry_t ent0_q, ent0_d;
  fetch_entry_t ent1_q, ent1_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop_eff;
  logic         push_eff;

  assign pop_eff  = pop_i & (occ_q != 2'd0);
  assign push_eff = push_i & ((occ_q != 2'd2) | pop_eff);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    if (flush_i) begin
      occ_d = 2'd0;
    end else begin
      unique case ({push_eff, pop_eff})
        2'b01: begin
          ent0_d = ent1_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b10: begin
          if (occ_q == 2'd0) ent0_d = push_data_i;
          else               ent1_d = push_data_i;
          occ_d = occ_q + 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: shift up if full, otherwise replace the head.
          if (occ_q == 2'd2) begin
            ent0_d = ent1_q;
            ent1_d = push_data_i;
          end else begin
            ent0_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign head_o = ent0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator for a 1-cycle-latency imem with a 2-entry output buffer.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = mips_pkg::RESET_PC,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned BUF_DEPTH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
);

  localparam logic [31:0] PcSpan = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] PcLast = PcSpan - 32'd4;

  logic [31:0]  pc_req_q, pc_req_d;
  logic [31:0]  tag_pc_q, tag_pc_d;
  logic         inflight_q, inflight_d;
  logic         align_err_q, align_err_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  fetch_entry_t head;
  fetch_entry_t cap_entry;
  logic [1:0]   occ;
  logic         instr_valid;
  logic         deq;
  logic         fire;

  assign instr_valid = (occ != 2'd0);
  assign deq         = instr_valid & bus.instr_ready;

  // Issue only if the word would still have a slot once it returns next cycle.
  assign fire = !bus.redirect &&
                ((32'(occ) + 32'(inflight_q)) < (BUF_DEPTH + 32'(deq)));

  assign cap_entry.instr = bus.memdata;
  assign cap_entry.pc    = tag_pc_q;

  always_comb begin
    pc_req_d      = pc_req_q;
    tag_pc_d      = tag_pc_q;
    inflight_d    = 1'b0;
    align_err_d   = bus.redirect & (bus.redirect_pc[1:0] != 2'b00);
    fetch_count_d = fetch_count_q + 32'(deq);
    if (bus.redirect) begin
      pc_req_d = {bus.redirect_pc[31:2], 2'b00} % PcSpan;
    end else if (fire) begin
      inflight_d = 1'b1;
      tag_pc_d   = pc_req_q;
      pc_req_d   = (pc_req_q >= PcLast) ? 32'd0 : pc_req_q + PC_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_req_q      <= RESET_PC;
      tag_pc_q      <= '0;
      inflight_q    <= 1'b0;
      align_err_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_req_q      <= pc_req_d;
      tag_pc_q      <= tag_pc_d;
      inflight_q    <= inflight_d;
      align_err_q   <= align_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  fetch_buf u_buf (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (inflight_q),
    .push_data_i (cap_entry),
    .pop_i       (deq),
    .flush_i     (bus.redirect),
    .head_o      (head),
    .occ_o       (occ)
  );

  assign bus.adr         = pc_req_q;
  assign bus.instr_valid = instr_valid;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.align_err   = align_err_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit with a 1-cycle-latency imem model.
module tb_ifetch_unit;

  localparam logic [31:0] W0 = 32'h0109_5020;
  localparam logic [31:0] W1 = 32'hAC0A_8000;
  localparam logic [31:0] W2 = 32'h8EB1_0000;
  localparam logic [31:0] W3 = 32'h2004_0001;
  localparam logic [31:0] W4 = 32'h2005_FFFF;

  logic clk;
  logic rst;
  logic [31:0] mem [256];

  int unsigned n_tests;
  int unsigned n_fail;

  ifetch_unit_if ifc ();

  ifetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .DEPTH_WORDS (256),
    .BUF_DEPTH   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ifc.memdata <= mem[ifc.adr[9:2]];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  // A capture into a full buffer with nothing leaving would lose a word.
  always @(negedge clk) begin
    if (rst && dut.inflight_q && !ifc.redirect && dut.u_buf.occ_o == 2'd2 &&
        !(ifc.instr_valid && ifc.instr_ready))
      check_val("no_overflow", 32'(dut.u_buf.occ_o) + 32'd1, 32'd2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] data);
    check_val({tag, "_valid"}, 32'(ifc.instr_valid), 32'd1);
    check_val({tag, "_pc"}, ifc.instr_pc, pc);
    check_val({tag, "_instr"}, ifc.instr, data);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = target;
    tick();
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[0] = W0;
    mem[1] = W1;
    mem[2] = W2;
    mem[3] = W3;
    mem[4] = W4;

    rst             = 1'b0;
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = '0;
    ifc.instr_ready = 1'b1;
    tick();
    tick();
    check_val("rst_valid", 32'(ifc.instr_valid), 32'd0);
    check_val("rst_instr", ifc.instr, 32'd0);
    check_val("rst_pc", ifc.instr_pc, 32'd0);
    check_val("rst_align", 32'(ifc.align_err), 32'd0);
    check_val("rst_count", ifc.fetch_count, 32'd0);
    check_val("rst_adr", ifc.adr, 32'd0);

    // Stream from reset: valid two edges after release, then one word per cycle.
    rst = 1'b1;
    tick();
    check_val("s_first_valid", 32'(ifc.instr_valid), 32'd0);
    check_val("s_first_adr", ifc.adr, 32'd4);
    tick();
    expect_head("s0", 32'h0, W0);
    check_val("s0_count", ifc.fetch_count, 32'd0);
    tick(); expect_head("s4", 32'h4, W1);
    tick(); expect_head("s8", 32'h8, W2);
    tick(); expect_head("s12", 32'hC, W3);
    tick(); expect_head("s16", 32'h10, W4);
    check_val("s_count", ifc.fetch_count, 32'd4);

    // Redirect back to 4, then stall with the head at 0xAC0A8000.
    pulse_redirect(32'h4);
    check_val("r4_k_valid", 32'(ifc.instr_valid), 32'd0);
    check_val("r4_branch_count", ifc.fetch_count, 32'd5);
    tick();
    check_val("r4_k1_valid", 32'(ifc.instr_valid), 32'd0);
    tick();
    expect_head("r4_tgt", 32'h4, W1);
    ifc.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_head("stall", 32'h4, W1);
      check_val("stall_occ", 32'(dut.u_buf.occ_o), 32'd2);
      check_val("stall_adr", ifc.adr, 32'hC);
    end
    check_val("stall_count", ifc.fetch_count, 32'd5);
    ifc.instr_ready = 1'b1;
    tick(); expect_head("unstall8", 32'h8, W2);
    tick(); expect_head("unstall12", 32'hC, W3);
    check_val("unstall_count", ifc.fetch_count, 32'd7);

    // Mid-stream redirect to 0x10: no stale word from 8/12 shows up.
    pulse_redirect(32'h10);
    check_val("r10_k_valid", 32'(ifc.instr_valid), 32'd0);
    tick();
    check_val("r10_k1_valid", 32'(ifc.instr_valid), 32'd0);
    tick();
    expect_head("r10_tgt", 32'h10, W4);
    check_val("r10_count", ifc.fetch_count, 32'd8);

    // Misaligned redirect: single align_err pulse, address forced to 0xC.
    pulse_redirect(32'h0000_000E);
    check_val("mis_align_on", 32'(ifc.align_err), 32'd1);
    check_val("mis_k_valid", 32'(ifc.instr_valid), 32'd0);
    tick();
    check_val("mis_align_off", 32'(ifc.align_err), 32'd0);
    check_val("mis_k1_valid", 32'(ifc.instr_valid), 32'd0);
    tick();
    expect_head("mis_tgt", 32'hC, W3);
    check_val("mis_count", ifc.fetch_count, 32'd9);

    // Back-to-back redirects: last wins, its target is reduced modulo 0x400.
    pulse_redirect(32'h8);
    pulse_redirect(32'h0000_1010);
    check_val("b2b_k1_valid", 32'(ifc.instr_valid), 32'd0);
    check_val("b2b_align", 32'(ifc.align_err), 32'd0);
    tick();
    check_val("b2b_k2_valid", 32'(ifc.instr_valid), 32'd0);
    tick();
    expect_head("b2b_tgt", 32'h10, W4);
    check_val("b2b_count", ifc.fetch_count, 32'd10);

    // Wrap from the last word back to 0.
    pulse_redirect(32'h3FC);
    tick();
    tick();
    expect_head("wrap_3fc", 32'h3FC, 32'hDEAD_00FF);
    tick(); expect_head("wrap_0", 32'h0, W0);
    tick(); expect_head("wrap_4", 32'h4, W1);
    check_val("wrap_count", ifc.fetch_count, 32'd13);

    // Reset while stalled with a full buffer.
    ifc.instr_ready = 1'b0;
    tick();
    check_val("rs_occ", 32'(dut.u_buf.occ_o), 32'd2);
    expect_head("rs_head", 32'h4, W1);
    rst = 1'b0;
    tick();
    check_val("rs_valid", 32'(ifc.instr_valid), 32'd0);
    check_val("rs_count", ifc.fetch_count, 32'd0);
    check_val("rs_adr", ifc.adr, 32'd0);
    rst             = 1'b1;
    ifc.instr_ready = 1'b1;
    tick();
    check_val("rs_rel_valid", 32'(ifc.instr_valid), 32'd0);
    tick();
    expect_head("rs_restart", 32'h0, W0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch initiator for the single-cycle-latency synchronous instruction memory (imem). It drives byte addresses to imem, tags each request with its PC, and captures the returned word one cycle later into a 2-entry buffer. It presents instructions to decode with a valid/ready handshake and handles branch/jump redirects by flushing in-flight and buffered words. It sits between the PC/branch logic and the decode stage of the 32-bit MIPS core.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
DEPTH_WORDS, 256, imem depth in words; PC wraps modulo 4*DEPTH_WORDS bytes
BUF_DEPTH, 2, output buffer entries; fixed at 2, the minimum for full throughput with 1-cycle memory latency

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-low reset
adr  out  32  byte address to imem, sampled by imem at every posedge
memdata  in  32  imem read data; valid the cycle after adr was sampled
redirect  in  1  one-cycle pulse: discard stream, restart at redirect_pc
redirect_pc  in  32  new byte address, qualified by redirect
instr_ready  in  1  decode accepts instr this cycle
instr_valid  out  1  instr/instr_pc hold a valid fetched word
instr  out  32  instruction word at buffer head
instr_pc  out  32  byte address of instr
align_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0
fetch_count  out  32  count of instructions accepted by decode (valid & ready)

Behaviour:
- Reset (rst==0 at posedge): pc_req=RESET_PC, inflight=0, buffer empty, instr_valid=0, instr=0, instr_pc=0, align_err=0, fetch_count=0. Reset overrides redirect and handshake.
- adr is the registered pc_req, driven directly. Request "fires" at an edge when occ + inflight - deq < 2, where deq = instr_valid & instr_ready. On fire: inflight<=1, tag_pc<=pc_req, pc_req<=(pc_req+4) mod 4*DEPTH_WORDS. No fire: inflight<=0, pc_req holds.
- Capture: an edge with inflight==1 writes {memdata, tag_pc} into the buffer. The issue rule guarantees space, so overflow is impossible; the bench asserts this.
- Output: instr/instr_pc always show the buffer head; instr_valid = occ!=0. Head must not change while instr_valid & !instr_ready.
- Steady state with instr_ready held 1: one instruction per cycle. First instr_valid is 2 cycles after reset release (issue edge, capture edge).
- Stall: with instr_ready=0, at most 2 words are buffered and issue stops. When ready returns, there are no bubbles and no word is lost or duplicated.
- Redirect at edge k, taking priority over issue, capture and deq:
  - buffer cleared, inflight<=0 (the returning word is dropped), pc_req<={redirect_pc[31:2],2'b00}.
  - instr_valid=0 after k. The target word is valid after edge k+2.
  - An instruction handshaked in the same cycle as redirect counts in fetch_count (the branch itself).
- align_err pulses for 1 cycle after edge k when redirect_pc[1:0]!=0. The address is force-aligned.
- Wrap: PC at 4*DEPTH_WORDS-4 increments to 0. Redirect targets are also reduced modulo 4*DEPTH_WORDS.
- fetch_count increments on each deq and wraps at 2^32.
- Back-to-back redirects: the last one wins. Each one flushes.

Decomposition:
- Shared package mips_pkg:
  - WORD_W=32
  - RESET_PC
  - PC_INC=4
  - fetch entry struct {instr[31:0], pc[31:0]}
- One sub-module fetch_buf: 2-entry FIFO of fetch entries with push, pop, flush, occ[1:0]. Flush has priority over push/pop.
- The top holds pc_req, inflight/tag_pc, issue logic and counters.

Test Plan:
- Reset + stream: imem model preloaded with 0x01095020, 0xAC0A8000, 0x8EB10000, 0x20040001, 0x2005FFFF; instr_ready=1; release rst -> instr_valid rises 2 cycles later; words appear in order with instr_pc 0, 4, 8, 12, 16 on consecutive cycles.
- Stall: drop instr_ready for 5 cycles while the head is 0xAC0A8000 -> head stable at pc=4, occ=2, adr frozen at 12; raise ready -> 0xAC0A8000, 0x8EB10000, 0x20040001 on consecutive cycles.
- Redirect: pulse redirect with redirect_pc=0x10 mid-stream -> instr_valid=0 for 2 cycles, then 0x2005FFFF at pc=0x10; no stale word from pc 8 or 12 is presented.
- Misaligned redirect: redirect_pc=0x0000000E -> align_err pulses once; the next valid word has instr_pc=0x0C and value 0x20040001.
- Wrap: redirect to 0x3FC with ready=1 -> instr_pc sequence 0x3FC, 0x000, 0x004.
- Reset mid-stall with occ=2 -> next cycle instr_valid=0 and fetch_count=0; the stream restarts at pc 0 with 0x01095020.
